// File: rtl/change_dispenser_if.sv
// Coin-payout bus between a vending controller and the change dispenser.
// Coin fields use the acceptor's one-hot encoding: bit0 = 1 zl, bit1 = 2 zl, bit2 = 5 zl.
interface change_dispenser_if #(
    parameter int AMOUNT_W = 8
);
    logic                start;
    logic [AMOUNT_W-1:0] amount;
    logic [2:0]          hopper_empty;
    logic                coin_ack;
    logic [2:0]          coin_out;
    logic                busy;
    logic                done;
    logic                error;
    logic [AMOUNT_W-1:0] paid;
    logic [AMOUNT_W-1:0] remaining;

    modport master (
        output start, amount, hopper_empty, coin_ack,
        input  coin_out, busy, done, error, paid, remaining
    );

    modport slave (
        input  start, amount, hopper_empty, coin_ack,
        output coin_out, busy, done, error, paid, remaining
    );
endinterface

// File: rtl/change_dispenser.sv
// Change dispenser: pays a zl amount greedily from a 5/2/1 zl hopper, confirming each
// coin on the coin-passed sensor and retiring tubes that never report a coin.
module change_dispenser #(
    parameter int AMOUNT_W     = 8,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int ACK_TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                reset,
    change_dispenser_if.slave   bus
);
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_EJECT, S_WAIT_ACK, S_GAP, S_FIN, S_FAULT
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [2:0]          r_den;
    logic [2:0]          w_den_next;
    logic [2:0]          r_jam;
    logic                w_jam_set;
    logic                r_acked;
    logic                r_ack_d;
    logic [2:0]          r_coin_out;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic [AMOUNT_W-1:0] r_paid;
    logic [AMOUNT_W-1:0] r_remaining;
    logic                w_ok5;
    logic                w_ok2;
    logic                w_ok1;
    logic [2:0]          w_choice;
    logic                w_ack_take;
    logic                w_start_take;

    function automatic logic [AMOUNT_W-1:0] den_value(input logic [2:0] oh);
        case (oh)
            3'b100:  den_value = AMOUNT_W'(5);
            3'b010:  den_value = AMOUNT_W'(2);
            3'b001:  den_value = AMOUNT_W'(1);
            default: den_value = {AMOUNT_W{1'b0}};
        endcase
    endfunction

    // Largest coin that fits the debt from a tube that is neither empty nor jammed.
    assign w_ok5    = !bus.hopper_empty[2] && !r_jam[2] && (r_remaining >= AMOUNT_W'(5));
    assign w_ok2    = !bus.hopper_empty[1] && !r_jam[1] && (r_remaining >= AMOUNT_W'(2));
    assign w_ok1    = !bus.hopper_empty[0] && !r_jam[0] && (r_remaining >= AMOUNT_W'(1));
    assign w_choice = w_ok5 ? 3'b100 : (w_ok2 ? 3'b010 : (w_ok1 ? 3'b001 : 3'b000));

    // Only the first rising sensor edge per coin counts, and only while a coin is in flight.
    assign w_ack_take   = ((r_state == S_EJECT) || (r_state == S_WAIT_ACK)) &&
                          bus.coin_ack && !r_ack_d && !r_acked;
    assign w_start_take = (r_state == S_IDLE) && bus.start;
    assign w_den_next   = (r_state == S_SELECT) ? w_choice : r_den;

    // Next-state and phase-counter logic.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_jam_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = {CNT_W{1'b0}};
                if (bus.start) begin
                    if (bus.amount == {AMOUNT_W{1'b0}}) w_next = S_FIN;
                    else                                w_next = S_SELECT;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_SELECT: begin
                w_cnt_next = {CNT_W{1'b0}};
                if (w_choice != 3'b000) w_next = S_EJECT;
                else                    w_next = S_FAULT;
            end
            S_EJECT: begin
                if (r_cnt == CNT_W'(PULSE_CYCLES - 1)) begin
                    w_cnt_next = {CNT_W{1'b0}};
                    if (r_acked || w_ack_take) w_next = S_GAP;
                    else                       w_next = S_WAIT_ACK;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            S_WAIT_ACK: begin
                if (w_ack_take) begin
                    w_next     = S_GAP;
                    w_cnt_next = {CNT_W{1'b0}};
                end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                    w_next     = S_SELECT;
                    w_cnt_next = {CNT_W{1'b0}};
                    w_jam_set  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            S_GAP: begin
                if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    w_cnt_next = {CNT_W{1'b0}};
                    if (r_remaining == {AMOUNT_W{1'b0}}) w_next = S_FIN;
                    else                                 w_next = S_SELECT;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            S_FIN:   w_next = S_IDLE;
            S_FAULT: w_next = S_IDLE;
            default: begin
                w_next     = S_IDLE;
                w_cnt_next = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and phase-counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Tally, jam mask and registered outputs; done/error/busy trail the FIN/FAULT state by a cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_den       <= 3'b000;
            r_jam       <= 3'b000;
            r_acked     <= 1'b0;
            r_ack_d     <= 1'b0;
            r_coin_out  <= 3'b000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_paid      <= {AMOUNT_W{1'b0}};
            r_remaining <= {AMOUNT_W{1'b0}};
        end else begin
            r_ack_d    <= bus.coin_ack;
            r_den      <= w_den_next;
            r_coin_out <= (w_next == S_EJECT) ? w_den_next : 3'b000;
            r_done     <= (r_state == S_FIN) || (r_state == S_FAULT);
            if (r_state == S_SELECT) r_acked <= 1'b0;
            else if (w_ack_take)     r_acked <= 1'b1;
            else                     r_acked <= r_acked;
            if (w_start_take) begin
                r_remaining <= bus.amount;
                r_paid      <= {AMOUNT_W{1'b0}};
                r_error     <= 1'b0;
                r_jam       <= 3'b000;
                r_busy      <= 1'b1;
            end else begin
                if (w_ack_take) begin
                    r_remaining <= r_remaining - den_value(r_den);
                    r_paid      <= r_paid + den_value(r_den);
                end
                if (w_jam_set)            r_jam   <= r_jam | r_den;
                if (r_state == S_FAULT)   r_error <= 1'b1;
                if (r_done)               r_busy  <= 1'b0;
            end
        end
    end

    assign bus.coin_out  = r_coin_out;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.error     = r_error;
    assign bus.paid      = r_paid;
    assign bus.remaining = r_remaining;
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Pays out change as physical coins once a vending transaction completes.
- Takes a change amount in zł and drives coin-eject strobes to a three-tube hopper (1, 2 and 5 zł).
- Confirms each coin through the hopper's coin-passed sensor.
- Uses the same one-hot coin encoding as the coin-acceptor input (bit0 = 1 zł, bit1 = 2 zł, bit2 = 5 zł), so it is the payout end of the coin interface.

Parameters:
- AMOUNT_W, 8, width of the amount and tally buses.
- PULSE_CYCLES, 4, eject strobe width in clk cycles (>=1).
- GAP_CYCLES, 2, idle cycles between coins (>=1).
- ACK_TIMEOUT, 255, cycles to wait for coin_ack before declaring a tube jammed.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to dispense `amount`.
- amount  input  AMOUNT_W  change to pay, in zł; sampled with start.
- hopper_empty  input  3  per-tube empty flags (bit0 = 1 zł, bit1 = 2 zł, bit2 = 5 zł).
- coin_ack  input  1  coin-passed sensor, synchronous; a level held high counts once.
- coin_out  output  3  one-hot eject strobe to the hopper.
- busy  output  1  transaction in progress.
- done  output  1  one-cycle pulse when a transaction ends, whether paid in full or faulted.
- error  output  1  change could not be made; sticky until the next accepted start.
- paid  output  AMOUNT_W  zł dispensed in the current or last transaction.
- remaining  output  AMOUNT_W  zł still owed.

Behaviour:
- Clock and reset:
  - One clock domain; all outputs are registered.
  - Reset is asynchronous and active-low.
  - While reset is low: coin_out=0, busy=0, done=0, error=0, paid=0, remaining=0, FSM=IDLE, jam mask cleared.
- FSM states: IDLE, SELECT, EJECT, WAIT_ACK, GAP, FIN, FAULT.
- IDLE:
  - start sampled at edge k loads remaining=amount, clears paid, error and the jam mask, and sets busy=1 from k+1.
  - amount==0 goes to FIN; otherwise goes to SELECT.
  - start is ignored in every state other than IDLE.
- SELECT:
  - Candidate denominations are d in {5,2,1} with d <= remaining, hopper_empty[d]=0 and not jammed.
  - The largest candidate is chosen; next state is EJECT.
  - No candidate goes to FAULT.
  - hopper_empty is evaluated only in SELECT.
- EJECT:
  - coin_out = one-hot(d) for exactly PULSE_CYCLES cycles, starting the cycle after SELECT (first strobe at k+2 after start).
  - Then go to WAIT_ACK, or to GAP if the ack was already taken during the pulse.
- Ack handling:
  - A coin_ack rising edge seen in EJECT or WAIT_ACK is accepted once per coin: remaining -= d, paid += d in the same update.
  - Acks in any other state are ignored.
- WAIT_ACK:
  - Accepted ack goes to GAP.
  - After ACK_TIMEOUT cycles with no ack (counted from entering WAIT_ACK): set jam bit for d and go to SELECT; remaining and paid are unchanged.
- GAP: GAP_CYCLES cycles with coin_out=0, then FIN if remaining==0, else SELECT.
- FIN: done=1 for one cycle, busy=0 from the next cycle, then IDLE.
- FAULT:
  - error=1 and done=1 for one cycle, then IDLE.
  - remaining holds the unpaid amount and paid holds what was dispensed; both stay until the next start.
- Arithmetic:
  - Unsigned, AMOUNT_W bits.
  - remaining never underflows, because d <= remaining is guaranteed in SELECT.
  - paid + remaining == amount at all times during a transaction.
- Reset mid-transaction drops coin_out in the same instant (asynchronous). No partial tally is kept.
- coin_out is never multi-hot and is never asserted outside EJECT.

Test Plan:
1. Normal payout:
   - Stimulus: amount=8, hopper_empty=000, ack 3 cycles after each strobe.
   - Required: strobes 100, 010, 001, each high PULSE_CYCLES cycles and separated by >=GAP_CYCLES; paid=8, remaining=0; one done pulse; error=0.
2. Zero change:
   - Stimulus: amount=0.
   - Required: done pulses at k+2, coin_out never asserted, busy low from k+3, paid=0.
3. Empty 2 zł tube:
   - Stimulus: amount=4, hopper_empty=010.
   - Required: four 001 strobes, paid=4, error=0.
4. Cannot make change:
   - Stimulus: amount=7, hopper_empty=011.
   - Required: one 100 strobe, then FAULT; error=1, paid=5, remaining=2, single done pulse.
5. Jammed tube:
   - Stimulus: amount=2, no ack for the 010 strobe; 1 zł coins acked normally.
   - Required: after ACK_TIMEOUT the 2 zł tube is jammed, then two 001 strobes; paid=2, error=0.
6. Ack levels and busy-start:
   - Stimulus: coin_ack held high 10 cycles; separately, start pulsed while busy.
   - Required: the held ack is counted once; the start is ignored and amount is unchanged.
7. Reset mid-eject:
   - Stimulus: reset driven low during EJECT.
   - Required: coin_out=000 immediately and all outputs at reset values.
